// File: rtl/pp_bank_scheduler.sv
// Ping-pong bank scheduler: hands the two attention-buffer banks to one
// writer and one reader in strict alternation, counts tiles over a pass and
// flags protocol misuse. All decisions are taken from registered state and
// every output comes straight from a flop.
module pp_bank_scheduler #(
  parameter int NUM_TILES = 8,
  parameter int CNT_W     = $clog2(NUM_TILES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             wr_req,
  input  logic             wr_done,
  output logic             wr_grant,
  output logic             wr_bank,
  input  logic             rd_req,
  input  logic             rd_done,
  output logic             rd_grant,
  output logic             rd_bank,
  output logic [1:0]       bank_full,
  output logic [CNT_W-1:0] tiles_written,
  output logic [CNT_W-1:0] tiles_read,
  output logic             busy,
  output logic             pass_done,
  output logic             err
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;
  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_t;

  localparam logic [CNT_W-1:0] TILES_MAX = CNT_W'(NUM_TILES);

  // A bank counts as occupied once it holds a complete tile.
  function automatic logic bank_held(input bank_t b);
    return (b == FULL) || (b == DRAINING);
  endfunction

  state_t           state_r, state_nxt;
  bank_t            bank_r [2];
  bank_t            bank_nxt [2];
  logic             wr_ptr_r, wr_ptr_nxt;
  logic             rd_ptr_r, rd_ptr_nxt;
  logic             wr_grant_nxt, wr_bank_nxt;
  logic             rd_grant_nxt, rd_bank_nxt;
  logic [CNT_W-1:0] tiles_written_nxt, tiles_read_nxt;
  logic             pass_done_nxt, err_nxt;
  logic [1:0]       bank_full_nxt;

  // Next-state computation for pass control, bank ownership, counters and errors.
  always_comb begin
    state_nxt         = state_r;
    bank_nxt[0]       = bank_r[0];
    bank_nxt[1]       = bank_r[1];
    wr_ptr_nxt        = wr_ptr_r;
    rd_ptr_nxt        = rd_ptr_r;
    wr_grant_nxt      = wr_grant;
    wr_bank_nxt       = wr_bank;
    rd_grant_nxt      = rd_grant;
    rd_bank_nxt       = rd_bank;
    tiles_written_nxt = tiles_written;
    tiles_read_nxt    = tiles_read;
    pass_done_nxt     = 1'b0;
    err_nxt           = err;

    // Done pulses without a matching grant (always the case in IDLE) are flagged and ignored.
    if ((wr_done && !wr_grant) || (rd_done && !rd_grant) ||
        ((state_r == IDLE) && (wr_done || rd_done))) begin
      err_nxt = 1'b1;
    end else begin
      err_nxt = err;
    end

    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt         = RUN;
          bank_nxt[0]       = EMPTY;
          bank_nxt[1]       = EMPTY;
          wr_ptr_nxt        = 1'b0;
          rd_ptr_nxt        = 1'b0;
          wr_grant_nxt      = 1'b0;
          rd_grant_nxt      = 1'b0;
          wr_bank_nxt       = 1'b0;
          rd_bank_nxt       = 1'b0;
          tiles_written_nxt = '0;
          tiles_read_nxt    = '0;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (tiles_read == TILES_MAX) begin
          // Every tile drained: close the pass.
          state_nxt     = IDLE;
          pass_done_nxt = 1'b1;
          wr_grant_nxt  = 1'b0;
          rd_grant_nxt  = 1'b0;
        end else begin
          // Writer side: finish the bank it owns, or claim the next one in order.
          if (wr_grant) begin
            if (wr_done) begin
              bank_nxt[wr_bank] = FULL;
              wr_grant_nxt      = 1'b0;
              wr_ptr_nxt        = ~wr_ptr_r;
              tiles_written_nxt = (tiles_written == TILES_MAX) ? tiles_written
                                                               : tiles_written + 1'b1;
            end else begin
              wr_grant_nxt = 1'b1;
            end
          end else if (wr_req && (bank_r[wr_ptr_r] == EMPTY) &&
                       (tiles_written < TILES_MAX)) begin
            bank_nxt[wr_ptr_r] = FILLING;
            wr_grant_nxt       = 1'b1;
            wr_bank_nxt        = wr_ptr_r;
          end else begin
            wr_grant_nxt = 1'b0;
          end

          // Reader side: release the bank it drained, or claim the next full one.
          if (rd_grant) begin
            if (rd_done) begin
              bank_nxt[rd_bank] = EMPTY;
              rd_grant_nxt      = 1'b0;
              rd_ptr_nxt        = ~rd_ptr_r;
              tiles_read_nxt    = (tiles_read == TILES_MAX) ? tiles_read
                                                            : tiles_read + 1'b1;
            end else begin
              rd_grant_nxt = 1'b1;
            end
          end else if (rd_req && (bank_r[rd_ptr_r] == FULL)) begin
            bank_nxt[rd_ptr_r] = DRAINING;
            rd_grant_nxt       = 1'b1;
            rd_bank_nxt        = rd_ptr_r;
          end else begin
            rd_grant_nxt = 1'b0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    bank_full_nxt = {bank_held(bank_nxt[1]), bank_held(bank_nxt[0])};
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      bank_r[0]     <= EMPTY;
      bank_r[1]     <= EMPTY;
      wr_ptr_r      <= 1'b0;
      rd_ptr_r      <= 1'b0;
      wr_grant      <= 1'b0;
      wr_bank       <= 1'b0;
      rd_grant      <= 1'b0;
      rd_bank       <= 1'b0;
      bank_full     <= 2'b00;
      tiles_written <= '0;
      tiles_read    <= '0;
      busy          <= 1'b0;
      pass_done     <= 1'b0;
      err           <= 1'b0;
    end else begin
      state_r       <= state_nxt;
      bank_r[0]     <= bank_nxt[0];
      bank_r[1]     <= bank_nxt[1];
      wr_ptr_r      <= wr_ptr_nxt;
      rd_ptr_r      <= rd_ptr_nxt;
      wr_grant      <= wr_grant_nxt;
      wr_bank       <= wr_bank_nxt;
      rd_grant      <= rd_grant_nxt;
      rd_bank       <= rd_bank_nxt;
      bank_full     <= bank_full_nxt;
      tiles_written <= tiles_written_nxt;
      tiles_read    <= tiles_read_nxt;
      busy          <= (state_nxt == RUN);
      pass_done     <= pass_done_nxt;
      err           <= err_nxt;
    end
  end

endmodule

// File: tb/tb_pp_bank_scheduler.sv
// Self-checking bench for pp_bank_scheduler with NUM_TILES=4: a cycle-by-cycle
// vector table for a full pass, then directed sequences for errors, start while
// busy, backpressure, reset mid-pass and a free-running streaming pass.
module tb_pp_bank_scheduler;

  localparam int NT = 4;
  localparam int CW = 3;

  logic          clk;
  logic          rst_n;
  logic          start, wr_req, wr_done, rd_req, rd_done;
  logic          wr_grant, wr_bank, rd_grant, rd_bank;
  logic [1:0]    bank_full;
  logic [CW-1:0] tiles_written, tiles_read;
  logic          busy, pass_done, err;

  int n_checks = 0;
  int n_pass   = 0;

  pp_bank_scheduler #(.NUM_TILES(NT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .wr_req(wr_req), .wr_done(wr_done), .wr_grant(wr_grant), .wr_bank(wr_bank),
    .rd_req(rd_req), .rd_done(rd_done), .rd_grant(rd_grant), .rd_bank(rd_bank),
    .bank_full(bank_full), .tiles_written(tiles_written), .tiles_read(tiles_read),
    .busy(busy), .pass_done(pass_done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  in;   // {start, wr_req, wr_done, rd_req, rd_done}
    logic [14:0] exp;  // same packing as outs()
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(input logic [4:0] in, input logic wg, input logic wb,
                              input logic rg, input logic rb, input logic [1:0] bf,
                              input logic [2:0] tw, input logic [2:0] tr,
                              input logic bz, input logic pd, input logic er);
    vec_t v;
    v.in  = in;
    v.exp = {wg, wb, rg, rb, bf, tw, tr, bz, pd, er};
    return v;
  endfunction

  function automatic logic [14:0] outs();
    return {wr_grant, wr_bank, rd_grant, rd_bank, bank_full,
            tiles_written, tiles_read, busy, pass_done, err};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [4:0] in);
    {start, wr_req, wr_done, rd_req, rd_done} = in;
  endtask

  initial begin
    int wr_q[$];
    int rd_q[$];
    logic pw, pr;
    int wa, ra, pd_cnt;
    bit seen;
    logic [3:0] wr_ord, rd_ord;

    rst_n = 1'b0;
    set_in(5'b00000);

    // Full pass, one row per clock edge.
    vecs[0]  = mk(5'b10000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    vecs[1]  = mk(5'b01000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    vecs[2]  = mk(5'b00100, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'd1, 3'd0, 1'b1, 1'b0, 1'b0);
    vecs[3]  = mk(5'b01010, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 3'd1, 3'd0, 1'b1, 1'b0, 1'b0);
    vecs[4]  = mk(5'b00101, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 3'd2, 3'd1, 1'b1, 1'b0, 1'b0);
    vecs[5]  = mk(5'b00010, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 3'd2, 3'd1, 1'b1, 1'b0, 1'b0);
    vecs[6]  = mk(5'b01000, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 3'd2, 3'd1, 1'b1, 1'b0, 1'b0);
    vecs[7]  = mk(5'b00101, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 3'd3, 3'd2, 1'b1, 1'b0, 1'b0);
    vecs[8]  = mk(5'b01010, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 3'd3, 3'd2, 1'b1, 1'b0, 1'b0);
    vecs[9]  = mk(5'b00101, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 3'd4, 3'd3, 1'b1, 1'b0, 1'b0);
    vecs[10] = mk(5'b01010, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 3'd4, 3'd3, 1'b1, 1'b0, 1'b0);
    vecs[11] = mk(5'b01001, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 3'd4, 3'd4, 1'b1, 1'b0, 1'b0);
    vecs[12] = mk(5'b00000, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 3'd4, 3'd4, 1'b0, 1'b1, 1'b0);
    vecs[13] = mk(5'b00000, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 3'd4, 3'd4, 1'b0, 1'b0, 1'b0);

    // Reset held for two edges.
    tick();
    tick();
    check("reset_outputs", 32'(outs()), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      set_in(vecs[i].in);
      tick();
      check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end
    set_in(5'b00000);

    // Spurious wr_done, then start while busy.
    start = 1'b1; tick(); start = 1'b0;
    check("restart_clears", 32'({busy, tiles_written}), 32'({1'b1, 3'd0}));
    wr_done = 1'b1; tick(); wr_done = 1'b0;
    check("spurious_wr_done", 32'({err, tiles_written, wr_grant}), 32'({1'b1, 3'd0, 1'b0}));
    wr_req = 1'b1; tick(); wr_req = 1'b0;
    check("grant_after_err", 32'({wr_grant, wr_bank}), 32'({1'b1, 1'b0}));
    wr_done = 1'b1; tick(); wr_done = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    check("start_while_busy", 32'({busy, tiles_written, bank_full, err, pass_done}),
          32'({1'b1, 3'd1, 2'b01, 1'b1, 1'b0}));
    tick();
    check("err_sticky", 32'(err), 32'd1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("reset_clears_err", 32'(outs()), 32'd0);

    // Backpressure with an idle reader, then freed-bank reuse.
    start = 1'b1; tick(); start = 1'b0;
    wr_req = 1'b1; tick();
    wr_done = 1'b1; tick(); wr_done = 1'b0;
    tick();
    check("bp_grant_b1", 32'({wr_grant, wr_bank}), 32'({1'b1, 1'b1}));
    wr_done = 1'b1; tick(); wr_done = 1'b0;
    tick(); tick(); tick();
    check("bp_full_stall", 32'({wr_grant, bank_full}), 32'({1'b0, 2'b11}));
    rd_req = 1'b1; tick(); rd_req = 1'b0;
    check("bp_rd_grant", 32'({rd_grant, rd_bank, wr_grant}), 32'({1'b1, 1'b0, 1'b0}));
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    check("bp_no_same_cycle_reuse", 32'({wr_grant, bank_full}), 32'({1'b0, 2'b10}));
    tick();
    check("bp_reuse_b0", 32'({wr_grant, wr_bank, tiles_written, tiles_read}),
          32'({1'b1, 1'b0, 3'd2, 3'd1}));

    // Reset in the middle of that pass.
    wr_req = 1'b0;
    rst_n = 1'b0; tick();
    check("midpass_reset", 32'(outs()), 32'd0);
    rst_n = 1'b1; tick();
    check("midpass_no_done", 32'({busy, pass_done}), 32'd0);

    // Free-running pass, done 5 cycles after each grant.
    pw = 1'b0; pr = 1'b0; wa = 0; ra = 0; pd_cnt = 0; seen = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    wr_req = 1'b1; rd_req = 1'b1;
    for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
      tick();
      wr_done = 1'b0; rd_done = 1'b0;
      if (pass_done) begin pd_cnt++; seen = 1'b1; end
      if (wr_grant && !pw) begin wr_q.push_back(int'(wr_bank)); wa = 0; end
      if (rd_grant && !pr) begin rd_q.push_back(int'(rd_bank)); ra = 0; end
      pw = wr_grant; pr = rd_grant;
      if (wr_grant) begin wa++; if (wa == 5) wr_done = 1'b1; end
      if (rd_grant) begin ra++; if (ra == 5) rd_done = 1'b1; end
    end
    check("stream_timeout", 32'(seen), 32'd1);
    wr_req = 1'b0; rd_req = 1'b0; wr_done = 1'b0; rd_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (pass_done) pd_cnt++;
    end
    wr_ord = 4'd0; rd_ord = 4'd0;
    foreach (wr_q[i]) wr_ord = {wr_ord[2:0], wr_q[i][0]};
    foreach (rd_q[i]) rd_ord = {rd_ord[2:0], rd_q[i][0]};
    check("stream_wr_order", 32'({wr_q.size(), wr_ord}), 32'({32'd4, 4'b0101}) & 32'hFFFFFFFF);
    check("stream_rd_order", 32'({rd_q.size(), rd_ord}), 32'({32'd4, 4'b0101}) & 32'hFFFFFFFF);
    check("stream_pass_done_once", 32'(pd_cnt), 32'd1);
    check("stream_end_state", 32'({busy, err, tiles_written, tiles_read}),
          32'({1'b0, 1'b0, 3'd4, 3'd4}));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pp_bank_scheduler.md
Name: pp_bank_scheduler

Overview:
Sequences ownership of the two banks of the multi-head-attention ping-pong buffer between one producer (tile writer) and one consumer (systolic matmul reader). Tracks per-bank state (EMPTY/FILLING/FULL/DRAINING) and grants banks in strict alternation, so tiles are consumed in fill order. Counts tiles over a pass and flags completion and protocol errors. Sits between the input slicer/writer, the read-address controller and the matmul wrapper.

Parameters:
NUM_TILES, 8, tiles per pass; must be >= 1
CNT_W, $clog2(NUM_TILES+1), width of the tile counters (derived)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  pulse; begins a pass of NUM_TILES tiles
wr_req  in  1  writer requests a bank to fill (level)
wr_done  in  1  pulse; writer finished filling the granted bank
wr_grant  out  1  writer owns wr_bank
wr_bank  out  1  bank index granted to the writer
rd_req  in  1  reader requests a full bank (level)
rd_done  in  1  pulse; reader finished draining the granted bank
rd_grant  out  1  reader owns rd_bank
rd_bank  out  1  bank index granted to the reader
bank_full  out  2  bit i = bank i is FULL or DRAINING
tiles_written  out  CNT_W  tiles filled this pass
tiles_read  out  CNT_W  tiles drained this pass
busy  out  1  pass in progress
pass_done  out  1  one-cycle pulse at end of pass
err  out  1  sticky protocol-error flag

Behaviour:
- Reset (rst_n=0 on a clk edge): both banks EMPTY; wr_ptr=rd_ptr=0; FSM IDLE. Outputs: wr_grant=0, wr_bank=0, rd_grant=0, rd_bank=0, bank_full=2'b00, tiles_written=0, tiles_read=0, busy=0, pass_done=0, err=0. Reset mid-pass aborts with no completion pulse.
- Top FSM: IDLE -> RUN on start (counters, pointers and bank states cleared that cycle; busy=1 from the next cycle). RUN -> IDLE when tiles_read reaches NUM_TILES; pass_done=1 for exactly that transition cycle, and busy drops on the same edge. start while busy is ignored.
- All decisions use registered state only. Every output is registered.
- Write grant: in RUN, if wr_req=1, wr_grant=0, bank[wr_ptr]=EMPTY and tiles_written<NUM_TILES, then on the next edge bank[wr_ptr] becomes FILLING, wr_grant=1 and wr_bank=wr_ptr. Latency is 1 cycle from the sampled request.
- Write done: if wr_done=1 and wr_grant=1, then on the next edge bank[wr_bank] becomes FULL, wr_grant=0, wr_ptr toggles and tiles_written increments. wr_req is not required to stay high during the grant.
- Read grant: symmetric. Requires rd_req=1, rd_grant=0 and bank[rd_ptr]=FULL; the bank becomes DRAINING.
- Read done: if rd_done=1 and rd_grant=1, the bank becomes EMPTY, rd_grant=0, rd_ptr toggles and tiles_read increments.
- Consequences of the above:
  - At most one FILLING and one DRAINING bank at any time.
  - A bank freed by rd_done can be granted to the writer no earlier than 1 cycle after it reads EMPTY; there is no same-cycle reuse.
- Simultaneous wr_done and rd_done (on different banks): both take effect on the same edge.
- Full: both banks FULL/DRAINING -> wr_req stalls with wr_grant=0 until a bank empties.
- Empty: bank[rd_ptr] not FULL -> rd_req stalls.
- Protocol errors set err (sticky until reset; operation otherwise unaffected, and the offending pulse is ignored):
  - wr_done while wr_grant=0
  - rd_done while rd_grant=0
  - start-independent activity: wr_done or rd_done in IDLE
- Grant-and-done in the same cycle is impossible by construction: done is sampled only while the grant is registered high.
- Counters saturate at NUM_TILES. No write grants are issued once tiles_written=NUM_TILES.

Test Plan:
- NUM_TILES=4, rst_n held low 2 cycles: all outputs 0 and bank_full=2'b00. Then start, wr_req=1: wr_grant=1, wr_bank=0 exactly 2 edges after start.
- Streaming pass with NUM_TILES=4, writer and reader always requesting, done pulses 5 cycles after each grant: bank order is wr 0,1,0,1 and rd 0,1,0,1. tiles_read reaches 4, pass_done pulses once, busy=0 afterwards, err=0.
- Backpressure, reader idle, two tiles written: bank_full=2'b11 and a third wr_req gets no grant. A subsequent rd grant on bank 0 plus rd_done gives wr_grant=1 on bank 0 two edges after rd_done.
- wr_done and rd_done pulsed on the same cycle (banks 1 and 0): on the next edge bank 1 is FULL and bank 0 is EMPTY, and both counters increment.
- Spurious wr_done with wr_grant=0: err=1 and remains 1, counters unchanged. start pulsed while busy: no effect.
- Reset asserted mid-pass with tiles_written=2: all outputs return to reset values, no pass_done pulse, and a new start runs a clean pass.
